// File: rtl/sram_access_arbiter.sv
// Two-requester arbiter in front of a single-port SRAM: latches one command per grant,
// strobes the memory, waits out read latency and returns a one-cycle ack with read data.
// Optional build macro ARB_FIXED_PRIO_EN: port A wins every tie instead of round robin.
module sram_access_arbiter #(
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned MEM_RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_en,
    output logic              mem_re_weN,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              last_grant
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e     state_q;
    logic       owner_q;  // 0 = port A, 1 = port B
    logic       we_q;
    logic [2:0] lat_cnt_q;
    logic       a_win;
    logic       b_win;
    logic       sel_we;

    always_comb begin
        a_win = a_req & ~b_req;
        b_win = b_req & ~a_req;
        if (a_req && b_req) begin
`ifdef ARB_FIXED_PRIO_EN
            a_win = 1'b1;
`else
            // Round robin: the port that did not own the last access wins the tie.
            a_win = last_grant;
            b_win = ~last_grant;
`endif
        end
        sel_we = b_win ? b_we : a_we;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            lat_cnt_q  <= '0;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            a_rdata    <= '0;
            b_rdata    <= '0;
            mem_en     <= 1'b0;
            mem_re_weN <= 1'b1;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            a_ack  <= 1'b0;
            b_ack  <= 1'b0;
            mem_en <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (a_win || b_win) begin
                        // mem_addr/mem_wdata double as the command registers.
                        owner_q    <= b_win;
                        we_q       <= sel_we;
                        mem_re_weN <= ~sel_we;
                        mem_addr   <= b_win ? b_addr : a_addr;
                        mem_wdata  <= b_win ? b_wdata : a_wdata;
                        mem_en     <= 1'b1;
                        busy       <= 1'b1;
                        state_q    <= StIssue;
                    end
                end
                StIssue: begin
                    if (we_q) begin
                        a_ack   <= ~owner_q;
                        b_ack   <= owner_q;
                        state_q <= StResp;
                    end else begin
                        lat_cnt_q <= 3'(MEM_RD_LAT);
                        state_q   <= StWait;
                    end
                end
                StWait: begin
                    if (lat_cnt_q == 3'd1) begin
                        if (owner_q) begin
                            b_rdata <= mem_rdata;
                        end else begin
                            a_rdata <= mem_rdata;
                        end
                        a_ack   <= ~owner_q;
                        b_ack   <= owner_q;
                        state_q <= StResp;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 3'd1;
                    end
                end
                StResp: begin
                    last_grant <= owner_q;
                    busy       <= 1'b0;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
